// File: rtl/scratch_pad_pkg.sv
// Shared scratch pad definitions: geometry, log2 helper and stream-port state encoding.
package scratch_pad_pkg;

   function automatic int sp_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   localparam int SP_WIDTH      = 64;
   localparam int SP_WORDS      = 4096;
   localparam int SP_ADDR_WIDTH = sp_clog2(SP_WORDS);

   typedef logic [1:0] sp_state_t;

   localparam sp_state_t ST_IDLE  = 2'd0;
   localparam sp_state_t ST_ISSUE = 2'd1;
   localparam sp_state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/scratch_pad_stream_port_fifo.sv
// First-word fall-through FIFO holding read responses until the consumer takes them.
module sync_fifo_fwft
   import scratch_pad_pkg::*;
#(
   parameter int WIDTH = SP_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_empty,
   output logic             o_full
);

   localparam int IDX_BITS = sp_clog2(DEPTH);
   localparam int PTR_BITS = IDX_BITS + 1;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wptr;
   logic [PTR_BITS-1:0] r_rptr;
   logic                w_do_push;
   logic                w_do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[IDX_BITS-1:0] == r_rptr[IDX_BITS-1:0]) &&
                      (r_wptr[PTR_BITS-1] != r_rptr[PTR_BITS-1]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_dout    = r_mem[r_rptr[IDX_BITS-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + PTR_BITS'(1);
         if (w_do_pop)  r_rptr <= r_rptr + PTR_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr[IDX_BITS-1:0]] <= i_din;
   end

endmodule

// File: rtl/scratch_pad_stream_port.sv
// Burst front-end for one scratch pad port: splits commands into single-word
// requests and returns read data as a credit-limited ready/valid stream.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | cmd_ready high, waiting for a burst command
//   ST_ISSUE | issuing one word request per cycle while allowed
//   ST_DRAIN | all reads issued, waiting for every word to be consumed
module scratch_pad_stream_port
   import scratch_pad_pkg::*;
#(
   parameter int WIDTH       = SP_WIDTH,
   parameter int ADDR_WIDTH  = SP_ADDR_WIDTH,
   parameter int LEN_WIDTH   = 13,
   parameter int CREDITS     = 8,
   parameter int CREDIT_BITS = sp_clog2(CREDITS) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [WIDTH-1:0]      wdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   output logic [WIDTH-1:0]      rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  sp_rd_en,
   output logic                  sp_wr_en,
   output logic [ADDR_WIDTH-1:0] sp_addr,
   output logic [WIDTH-1:0]      sp_d,
   input  logic                  sp_full,
   input  logic                  sp_valid,
   input  logic [WIDTH-1:0]      sp_q,
   output logic                  sp_stall
);

   localparam logic [CREDIT_BITS-1:0] C_CREDITS = CREDIT_BITS'(CREDITS);

   sp_state_t              r_state;
   logic [ADDR_WIDTH-1:0]  r_addr;
   logic [LEN_WIDTH-1:0]   r_remain;
   logic                   r_write;
   logic                   r_done;
   logic [CREDIT_BITS-1:0] r_reserved;

   logic w_issue;
   logic w_rd_issue;
   logic w_wr_issue;
   logic w_last;
   logic w_push;
   logic w_pop;
   logic w_fifo_empty;
   logic w_fifo_full;

   // Issue is combinational on sp_full so a request never lands on a full port.
   assign w_issue    = (r_state == ST_ISSUE) && !sp_full &&
                       (r_write ? wdata_valid : (r_reserved < C_CREDITS));
   assign w_wr_issue = w_issue && r_write;
   assign w_rd_issue = w_issue && !r_write;
   assign w_last     = (r_remain == LEN_WIDTH'(1));
   assign w_pop      = !w_fifo_empty && rdata_ready;
   // Responses arriving with no reservation outstanding are dropped.
   assign w_push     = sp_valid && !w_fifo_full && (r_reserved != '0);

   assign cmd_ready   = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign wdata_ready = w_wr_issue;
   assign sp_wr_en    = w_wr_issue;
   assign sp_rd_en    = w_rd_issue;
   assign sp_addr     = r_addr;
   assign sp_d        = wdata;
   assign sp_stall    = w_fifo_full;
   assign rdata_valid = !w_fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_remain <= '0;
         r_write  <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_addr   <= cmd_addr;
                  r_remain <= cmd_len;
                  r_write  <= cmd_write;
                  if (cmd_len == '0) r_done  <= 1'b1;
                  else               r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  r_addr   <= r_addr + ADDR_WIDTH'(1);
                  r_remain <= r_remain - LEN_WIDTH'(1);
                  if (w_last) begin
                     if (r_write) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                     end else begin
                        r_state <= ST_DRAIN;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (r_reserved == '0) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A credit is held from read issue until the word is handed to the consumer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reserved <= '0;
      end else begin
         case ({w_rd_issue, w_pop})
            2'b10:   r_reserved <= r_reserved + CREDIT_BITS'(1);
            2'b01:   if (r_reserved != '0) r_reserved <= r_reserved - CREDIT_BITS'(1);
            default: r_reserved <= r_reserved;
         endcase
      end
   end

   sync_fifo_fwft #(
      .WIDTH (WIDTH),
      .DEPTH (CREDITS)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (sp_q),
      .i_pop   (w_pop),
      .o_dout  (rdata),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full)
   );

endmodule
